// File: rtl/mul_onehot_dec.sv
// Leading-one mask decoder with normalising shift: turns a one-hot MSB-first mask into a
// leading-zero count and left-shifts the mantissa by that count. Two registered stages with valid/ready.
module mul_onehot_dec #(
  parameter  int INPUT_WIDTH = 24,
  localparam int CNT_WIDTH   = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_mask,
  input  logic [INPUT_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_WIDTH-1:0]   out_lzc,
  output logic [INPUT_WIDTH-1:0] out_norm,
  output logic                   out_zero,
  output logic                   out_err
);

  logic                   s1_valid_reg;
  logic [INPUT_WIDTH-1:0] s1_data_reg;
  logic [CNT_WIDTH-1:0]   s1_lzc_reg;
  logic                   s1_zero_reg;
  logic                   s1_err_reg;
  logic                   s2_valid_reg;

  logic                   s1_adv;
  logic                   s2_adv;
  logic [CNT_WIDTH-1:0]   enc_lzc;
  logic                   enc_zero;
  logic                   enc_err;

  assign s2_adv    = !s2_valid_reg || out_ready;
  assign s1_adv    = !s1_valid_reg || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_reg;

  // Ascending scan so the highest set bit wins; a malformed mask falls back to MSB priority.
  always_comb begin
    enc_lzc = CNT_WIDTH'(INPUT_WIDTH);
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (in_mask[i]) enc_lzc = CNT_WIDTH'(INPUT_WIDTH - 1 - i);
    end
    enc_zero = ~|in_mask;
    enc_err  = |(in_mask & (in_mask - INPUT_WIDTH'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_lzc_reg   <= '0;
      s1_zero_reg  <= 1'b0;
      s1_err_reg   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg <= in_data;
        s1_lzc_reg  <= enc_lzc;
        s1_zero_reg <= enc_zero;
        s1_err_reg  <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      out_lzc      <= '0;
      out_norm     <= '0;
      out_zero     <= 1'b0;
      out_err      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_lzc  <= s1_lzc_reg;
        out_norm <= s1_zero_reg ? '0 : (s1_data_reg << s1_lzc_reg);
        out_zero <= s1_zero_reg;
        out_err  <= s1_err_reg;
      end
    end
  end

endmodule

// File: tb/tb_mul_onehot_dec.sv
// Directed testbench for mul_onehot_dec: decode vectors, back-to-back streaming,
// output stall with backpressure, and asynchronous reset with a full pipeline.
module tb_mul_onehot_dec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mask;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_lzc;
  logic [23:0] out_norm;
  logic        out_zero;
  logic        out_err;

  int asserts;
  int failures;

  // Expected-value tables, filled with hand-computed constants.
  logic [23:0] v_mask [5];
  logic [23:0] v_data [5];
  logic [4:0]  v_lzc  [5];
  logic [23:0] v_norm [5];
  logic        v_zero [5];
  logic        v_err  [5];

  mul_onehot_dec #(.INPUT_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lzc(out_lzc), .out_norm(out_norm), .out_zero(out_zero), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_spec_vectors();
    v_mask[0] = 24'h800000; v_data[0] = 24'hABCDEF; v_lzc[0] = 5'd0;  v_norm[0] = 24'hABCDEF; v_zero[0] = 0; v_err[0] = 0;
    v_mask[1] = 24'h000001; v_data[1] = 24'h000001; v_lzc[1] = 5'd23; v_norm[1] = 24'h800000; v_zero[1] = 0; v_err[1] = 0;
    v_mask[2] = 24'h000000; v_data[2] = 24'h123456; v_lzc[2] = 5'd24; v_norm[2] = 24'h000000; v_zero[2] = 1; v_err[2] = 0;
    v_mask[3] = 24'h000300; v_data[3] = 24'h000345; v_lzc[3] = 5'd14; v_norm[3] = 24'hD14000; v_zero[3] = 0; v_err[3] = 1;
    v_mask[4] = 24'h400000; v_data[4] = 24'h3FFFFF; v_lzc[4] = 5'd1;  v_norm[4] = 24'h7FFFFE; v_zero[4] = 0; v_err[4] = 0;
  endtask

  task automatic load_stall_vectors();
    v_mask[0] = 24'h400000; v_data[0] = 24'h3FFFFF; v_lzc[0] = 5'd1;  v_norm[0] = 24'h7FFFFE; v_zero[0] = 0; v_err[0] = 0;
    v_mask[1] = 24'h000010; v_data[1] = 24'h00001F; v_lzc[1] = 5'd19; v_norm[1] = 24'hF80000; v_zero[1] = 0; v_err[1] = 0;
    v_mask[2] = 24'h000000; v_data[2] = 24'hFFFFFF; v_lzc[2] = 5'd24; v_norm[2] = 24'h000000; v_zero[2] = 1; v_err[2] = 0;
    v_mask[3] = 24'h008001; v_data[3] = 24'h0000AB; v_lzc[3] = 5'd8;  v_norm[3] = 24'h00AB00; v_zero[3] = 0; v_err[3] = 1;
    v_mask[4] = 24'h000100; v_data[4] = 24'h123456; v_lzc[4] = 5'd15; v_norm[4] = 24'h2B0000; v_zero[4] = 0; v_err[4] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mask = '0; in_data = '0; out_ready = 1'b1;
    #2;
    asserts++;
    if ({out_valid, out_lzc, out_norm, out_zero, out_err} !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b lzc=%0d norm=%h zero=%b err=%b, want all 0",
               out_valid, out_lzc, out_norm, out_zero, out_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  // One isolated beat per vector; result checked two cycles after it is presented.
  task automatic test_decode();
    load_spec_vectors();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_mask = v_mask[k]; in_data = v_data[k];
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      asserts++;
      if (out_valid !== 1'b1 || out_lzc !== v_lzc[k] || out_norm !== v_norm[k] ||
          out_zero !== v_zero[k] || out_err !== v_err[k]) begin
        failures++;
        $display("FAIL decode_%0d: got valid=%b lzc=%0d norm=%h zero=%b err=%b, want valid=1 lzc=%0d norm=%h zero=%b err=%b",
                 k, out_valid, out_lzc, out_norm, out_zero, out_err, v_lzc[k], v_norm[k], v_zero[k], v_err[k]);
      end
      $display("decode %0d: mask=%h data=%h -> lzc=%0d norm=%h zero=%b err=%b",
               k, v_mask[k], v_data[k], out_lzc, out_norm, out_zero, out_err);
      @(posedge clk); #1;
    end
  endtask

  // Five beats on consecutive cycles with out_ready held high: one result per cycle, in order.
  task automatic test_back_to_back();
    load_spec_vectors();
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        in_valid = 1'b1; in_mask = v_mask[c]; in_data = v_data[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      asserts++;
      if (out_valid !== (c >= 2 && c <= 6) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_flow_c%0d: got out_valid=%b in_ready=%b, want out_valid=%b in_ready=1",
                 c, out_valid, in_ready, (c >= 2 && c <= 6));
      end
      if (c >= 2 && c <= 6) begin
        asserts++;
        if (out_lzc !== v_lzc[c-2] || out_norm !== v_norm[c-2] ||
            out_zero !== v_zero[c-2] || out_err !== v_err[c-2]) begin
          failures++;
          $display("FAIL b2b_data_%0d: got lzc=%0d norm=%h zero=%b err=%b, want lzc=%0d norm=%h zero=%b err=%b",
                   c-2, out_lzc, out_norm, out_zero, out_err, v_lzc[c-2], v_norm[c-2], v_zero[c-2], v_err[c-2]);
        end
        $display("b2b cycle %0d: beat %0d lzc=%0d norm=%h", c, c-2, out_lzc, out_norm);
      end
      @(posedge clk); #1;
    end
  endtask

  // out_ready low for cycles 3..5 of a five-beat stream.
  task automatic test_stall();
    int sent;
    int recv;
    logic want_ready;
    logic want_valid;
    load_stall_vectors();
    sent = 0; recv = 0;
    for (int c = 0; c < 20 && recv < 5; c++) begin
      in_valid  = (sent < 5);
      in_mask   = (sent < 5) ? v_mask[sent] : '0;
      in_data   = (sent < 5) ? v_data[sent] : '0;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      want_ready = !(c >= 3 && c <= 5);
      want_valid = (c >= 2 && c <= 9);
      asserts++;
      if (in_ready !== want_ready || out_valid !== want_valid) begin
        failures++;
        $display("FAIL stall_flow_c%0d: got in_ready=%b out_valid=%b, want in_ready=%b out_valid=%b",
                 c, in_ready, out_valid, want_ready, want_valid);
      end
      if (out_valid === 1'b1) begin
        asserts++;
        if (out_lzc !== v_lzc[recv] || out_norm !== v_norm[recv] ||
            out_zero !== v_zero[recv] || out_err !== v_err[recv]) begin
          failures++;
          $display("FAIL stall_data_c%0d_beat%0d: got lzc=%0d norm=%h zero=%b err=%b, want lzc=%0d norm=%h zero=%b err=%b",
                   c, recv, out_lzc, out_norm, out_zero, out_err, v_lzc[recv], v_norm[recv], v_zero[recv], v_err[recv]);
        end
      end
      $display("stall cycle %0d: in_ready=%b out_valid=%b out_ready=%b lzc=%0d norm=%h",
               c, in_ready, out_valid, out_ready, out_lzc, out_norm);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) recv++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    asserts++;
    if (sent != 5 || recv != 5) begin
      failures++;
      $display("FAIL stall_count: got sent=%0d received=%0d, want 5 and 5", sent, recv);
    end
  endtask

  task automatic test_reset_mid();
    load_stall_vectors();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_mask = v_mask[k]; in_data = v_data[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    asserts++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_full: got out_valid=%b in_ready=%b, want 1 and 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({out_valid, out_lzc, out_norm, out_zero, out_err} !== 31'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: got valid=%b lzc=%0d norm=%h zero=%b err=%b, want all 0",
               out_valid, out_lzc, out_norm, out_zero, out_err);
    end
    $display("reset mid-flight: out_valid=%b", out_valid);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_mask = 24'h800000; in_data = 24'h00000F;
    for (int c = 0; c < 3; c++) begin
      #1;
      asserts++;
      if (out_valid !== (c == 2)) begin
        failures++;
        $display("FAIL rstmid_valid_c%0d: got out_valid=%b, want %b", c, out_valid, (c == 2));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    #1;
    asserts++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_dup: got out_valid=%b, want 0", out_valid);
    end
  endtask

  // The post-reset beat's data is checked on the cycle it becomes visible.
  task automatic test_reset_mid_data();
    in_valid = 1'b1; in_mask = 24'h000080; in_data = 24'h000003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if (out_valid !== 1'b1 || out_lzc !== 5'd16 || out_norm !== 24'h030000 || out_zero !== 1'b0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_beat: got valid=%b lzc=%0d norm=%h zero=%b err=%b, want valid=1 lzc=16 norm=030000 zero=0 err=0",
               out_valid, out_lzc, out_norm, out_zero, out_err);
    end
    $display("post-reset beat: lzc=%0d norm=%h", out_lzc, out_norm);
    @(posedge clk); #1;
  endtask

  initial begin
    asserts = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
